// File: rtl/iact_router_buffered_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iact_router_buffered_if                                         |
// | Brief    : valid/ready handshake channel carrying one W-bit payload lane.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface iact_router_buffered_if #(
  parameter int W = 8
);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/iact_router_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iact_router_buffered                                            |
// | Brief    : 4-source / 4-destination buffered iact router, one FIFO per     |
// |            lane with per-destination served tracking for multicast.        |
// |            Optional select lock: define IACT_ROUTER_SEL_LOCK_EN.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module iact_router_buffered_lane #(
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          in_sel_i,
  input  logic [3:0]          en_i,
  input  logic [3:0]          in_valid_i,
  input  logic [3:0][W-1:0]   in_data_i,
  output logic [3:0]          in_ready_o,
  output logic [3:0]          out_valid_o,
  output logic [W-1:0]        out_data_o,
  input  logic [3:0]          out_ready_i,
  output logic                busy_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(FIFO_DEPTH - 1);

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       served_q, served_d;

  logic       w_not_full;
  logic       w_not_empty;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_hs;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_not_full  = (count_q < C_DEPTH);
  assign w_not_empty = (count_q != '0);

  generate
    for (genvar g = 0; g < 4; g++) begin : g_in_ready
      assign in_ready_o[g] = (in_sel_i == 2'(g)) & w_not_full;
    end
  endgenerate

  assign w_push      = in_valid_i[in_sel_i] & w_not_full;
  assign out_valid_o = {4{w_not_empty}} & en_i & ~served_q;
  assign out_data_o  = mem_q[rptr_q];
  assign w_hs        = out_valid_o & out_ready_i;
  // Pop once every enabled destination has taken the head, now or earlier.
  assign w_pop       = w_not_empty & ((en_i & ~(served_q | w_hs)) == 4'b0000);
  assign busy_o      = w_not_empty | (served_q != 4'b0000);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    served_d = served_q | w_hs;
    if (w_push) begin
      wptr_d = next_ptr(wptr_q);
    end
    if (w_pop) begin
      rptr_d   = next_ptr(rptr_q);
      served_d = 4'b0000;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      served_q <= 4'b0000;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      served_q <= served_d;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q] <= in_data_i[in_sel_i];
    end
  end
endmodule

module iact_router_buffered #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  iact_router_buffered_if.slave        GLB_address_in,
  iact_router_buffered_if.slave        north_address_in,
  iact_router_buffered_if.slave        south_address_in,
  iact_router_buffered_if.slave        horiz_address_in,
  iact_router_buffered_if.slave        GLB_data_in,
  iact_router_buffered_if.slave        north_data_in,
  iact_router_buffered_if.slave        south_data_in,
  iact_router_buffered_if.slave        horiz_data_in,
  iact_router_buffered_if.master       PE_address_out,
  iact_router_buffered_if.master       north_address_out,
  iact_router_buffered_if.master       south_address_out,
  iact_router_buffered_if.master       horiz_address_out,
  iact_router_buffered_if.master       PE_data_out,
  iact_router_buffered_if.master       north_data_out,
  iact_router_buffered_if.master       south_data_out,
  iact_router_buffered_if.master       horiz_data_out,
  input  logic [1:0]                   data_in_sel,
  input  logic [1:0]                   data_out_sel,
  output logic                         busy
);
  // Bit order on all 4-bit vectors: [0] GLB/PE, [1] north, [2] south, [3] horiz.
  logic [1:0]              w_in_sel;
  logic [1:0]              w_out_sel;
  logic [3:0]              w_en;

  logic [3:0]              w_a_in_valid,  w_d_in_valid;
  logic [3:0][ADDR_W-1:0]  w_a_in_data;
  logic [3:0][DATA_W-1:0]  w_d_in_data;
  logic [3:0]              w_a_in_ready,  w_d_in_ready;
  logic [3:0]              w_a_out_valid, w_d_out_valid;
  logic [3:0]              w_a_out_ready, w_d_out_ready;
  logic [ADDR_W-1:0]       w_a_head;
  logic [DATA_W-1:0]       w_d_head;
  logic                    w_a_busy, w_d_busy;

`ifdef IACT_ROUTER_SEL_LOCK_EN
  logic [1:0] in_sel_q;
  logic [1:0] out_sel_q;

  // Selects only follow the inputs while both lanes are drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sel_q  <= 2'd0;
      out_sel_q <= 2'd0;
    end else if (!busy) begin
      in_sel_q  <= data_in_sel;
      out_sel_q <= data_out_sel;
    end
  end

  assign w_in_sel  = in_sel_q;
  assign w_out_sel = out_sel_q;
`else
  assign w_in_sel  = data_in_sel;
  assign w_out_sel = data_out_sel;
`endif

  always_comb begin
    w_en = 4'b0001;
    case (w_out_sel)
      2'd0:    w_en = 4'b0001;
      2'd1:    w_en = 4'b1001;
      2'd2:    w_en = 4'b0111;
      default: w_en = 4'b1111;
    endcase
  end

  assign w_a_in_valid = {horiz_address_in.valid, south_address_in.valid,
                         north_address_in.valid, GLB_address_in.valid};
  assign w_a_in_data  = {horiz_address_in.data, south_address_in.data,
                         north_address_in.data, GLB_address_in.data};
  assign w_d_in_valid = {horiz_data_in.valid, south_data_in.valid,
                         north_data_in.valid, GLB_data_in.valid};
  assign w_d_in_data  = {horiz_data_in.data, south_data_in.data,
                         north_data_in.data, GLB_data_in.data};

  assign GLB_address_in.ready   = w_a_in_ready[0];
  assign north_address_in.ready = w_a_in_ready[1];
  assign south_address_in.ready = w_a_in_ready[2];
  assign horiz_address_in.ready = w_a_in_ready[3];
  assign GLB_data_in.ready      = w_d_in_ready[0];
  assign north_data_in.ready    = w_d_in_ready[1];
  assign south_data_in.ready    = w_d_in_ready[2];
  assign horiz_data_in.ready    = w_d_in_ready[3];

  assign w_a_out_ready = {horiz_address_out.ready, south_address_out.ready,
                          north_address_out.ready, PE_address_out.ready};
  assign w_d_out_ready = {horiz_data_out.ready, south_data_out.ready,
                          north_data_out.ready, PE_data_out.ready};

  assign PE_address_out.valid    = w_a_out_valid[0];
  assign north_address_out.valid = w_a_out_valid[1];
  assign south_address_out.valid = w_a_out_valid[2];
  assign horiz_address_out.valid = w_a_out_valid[3];
  assign PE_address_out.data     = w_a_head;
  assign north_address_out.data  = w_a_head;
  assign south_address_out.data  = w_a_head;
  assign horiz_address_out.data  = w_a_head;

  assign PE_data_out.valid       = w_d_out_valid[0];
  assign north_data_out.valid    = w_d_out_valid[1];
  assign south_data_out.valid    = w_d_out_valid[2];
  assign horiz_data_out.valid    = w_d_out_valid[3];
  assign PE_data_out.data        = w_d_head;
  assign north_data_out.data     = w_d_head;
  assign south_data_out.data     = w_d_head;
  assign horiz_data_out.data     = w_d_head;

  iact_router_buffered_lane #(
    .W          (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_addr_lane (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_sel_i    (w_in_sel),
    .en_i        (w_en),
    .in_valid_i  (w_a_in_valid),
    .in_data_i   (w_a_in_data),
    .in_ready_o  (w_a_in_ready),
    .out_valid_o (w_a_out_valid),
    .out_data_o  (w_a_head),
    .out_ready_i (w_a_out_ready),
    .busy_o      (w_a_busy)
  );

  iact_router_buffered_lane #(
    .W          (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_data_lane (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_sel_i    (w_in_sel),
    .en_i        (w_en),
    .in_valid_i  (w_d_in_valid),
    .in_data_i   (w_d_in_data),
    .in_ready_o  (w_d_in_ready),
    .out_valid_o (w_d_out_valid),
    .out_data_o  (w_d_head),
    .out_ready_i (w_d_out_ready),
    .busy_o      (w_d_busy)
  );

  assign busy = w_a_busy | w_d_busy;
endmodule
`default_nettype wire

// File: tb/tb_iact_router_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_iact_router_buffered                                         |
// | Brief    : randomized and scenario bench for iact_router_buffered against  |
// |            a queue-based reference model.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_iact_router_buffered;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        in_sel, out_sel;
  wire               busy;
  logic [3:0]        src_av, src_dv, dst_ar, dst_dr;
  logic [ADDR_W-1:0] src_a [4];
  logic [DATA_W-1:0] src_d [4];
  wire  [3:0]        a_rdy, d_rdy, a_ov, d_ov;
  wire  [ADDR_W-1:0] a_od [4];
  wire  [DATA_W-1:0] d_od [4];

  iact_router_buffered_if #(.W(ADDR_W)) ai [4] ();
  iact_router_buffered_if #(.W(ADDR_W)) ao [4] ();
  iact_router_buffered_if #(.W(DATA_W)) din [4] ();
  iact_router_buffered_if #(.W(DATA_W)) dout [4] ();

  generate
    for (genvar g = 0; g < 4; g++) begin : g_conn
      assign ai[g].valid   = src_av[g];
      assign ai[g].data    = src_a[g];
      assign a_rdy[g]      = ai[g].ready;
      assign din[g].valid  = src_dv[g];
      assign din[g].data   = src_d[g];
      assign d_rdy[g]      = din[g].ready;
      assign ao[g].ready   = dst_ar[g];
      assign a_ov[g]       = ao[g].valid;
      assign a_od[g]       = ao[g].data;
      assign dout[g].ready = dst_dr[g];
      assign d_ov[g]       = dout[g].valid;
      assign d_od[g]       = dout[g].data;
    end
  endgenerate

  iact_router_buffered #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .GLB_address_in    (ai[0]),
    .north_address_in  (ai[1]),
    .south_address_in  (ai[2]),
    .horiz_address_in  (ai[3]),
    .GLB_data_in       (din[0]),
    .north_data_in     (din[1]),
    .south_data_in     (din[2]),
    .horiz_data_in     (din[3]),
    .PE_address_out    (ao[0]),
    .north_address_out (ao[1]),
    .south_address_out (ao[2]),
    .horiz_address_out (ao[3]),
    .PE_data_out       (dout[0]),
    .north_data_out    (dout[1]),
    .south_data_out    (dout[2]),
    .horiz_data_out    (dout[3]),
    .data_in_sel       (in_sel),
    .data_out_sel      (out_sel),
    .busy              (busy)
  );

  // Reference model: one queue per lane, a served set per lane head, effective selects.
  logic [15:0] mqa [$];
  logic [15:0] mqd [$];
  logic [15:0] feed_a [$];
  logic [15:0] feed_d [$];
  logic [3:0]  srv [2];
  logic [1:0]  m_in, m_out;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Destination membership straight from the select names.
  function automatic logic [3:0] enabled(input logic [1:0] s);
    logic [3:0] e;
    e = 4'b0001;
    if (s == 2'd1 || s == 2'd3) e[3] = 1'b1;
    if (s == 2'd2 || s == 2'd3) begin
      e[1] = 1'b1;
      e[2] = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    mqa.delete();
    mqd.delete();
    srv[0] = 4'b0;
    srv[1] = 4'b0;
    m_in   = 2'd0;
    m_out  = 2'd0;
  endtask

  task automatic drive_feed();
    logic [15:0] w;
    src_av = 4'b0;
    src_dv = 4'b0;
    if (feed_a.size() != 0) begin
      w = feed_a[0];
      src_av = 4'hF;
      for (int i = 0; i < 4; i++) src_a[i] = w[ADDR_W-1:0];
    end
    if (feed_d.size() != 0) begin
      w = feed_d[0];
      src_dv = 4'hF;
      for (int i = 0; i < 4; i++) src_d[i] = w[DATA_W-1:0];
    end
  endtask

  // Compares one cycle at the falling edge, then advances the model to the next rising edge.
  task automatic step();
    logic [3:0]  e, er, ev, rdy, hs;
    logic [15:0] q [$];
    logic [15:0] w;
    logic [31:0] obs;
    logic        srcv, pushed, popped;
    bit          busy_m;
    @(negedge clk);
`ifndef IACT_ROUTER_SEL_LOCK_EN
    m_in  = in_sel;
    m_out = out_sel;
`endif
    e = enabled(m_out);
    busy_m = (mqa.size() != 0) || (mqd.size() != 0) || (srv[0] != 0) || (srv[1] != 0);
    check("busy", 32'(busy), 32'(busy_m));
    for (int L = 0; L < 2; L++) begin
      if (L == 0) q = mqa; else q = mqd;
      er = 4'b0;
      if (q.size() < DEPTH) er[m_in] = 1'b1;
      ev = (q.size() != 0) ? (e & ~srv[L]) : 4'b0;
      check(L ? "data_in_ready" : "addr_in_ready", 32'(L ? d_rdy : a_rdy), 32'(er));
      check(L ? "data_out_valid" : "addr_out_valid", 32'(L ? d_ov : a_ov), 32'(ev));
      for (int d = 0; d < 4; d++) begin
        if (ev[d]) begin
          obs = L ? 32'(d_od[d]) : 32'(a_od[d]);
          check($sformatf("%s_out[%0d]", L ? "data" : "addr", d), obs, 32'(q[0]));
        end
      end
      if (rst_n) begin
        rdy  = L ? dst_dr : dst_ar;
        hs   = ev & rdy;
        srcv = L ? src_dv[m_in] : src_av[m_in];
        w    = L ? 16'(src_d[m_in]) : 16'(src_a[m_in]);
        pushed = srcv && (q.size() < DEPTH);
        popped = (q.size() != 0) && ((e & ~(srv[L] | hs)) == 4'b0);
        if (popped) begin
          void'(q.pop_front());
          srv[L] = 4'b0;
        end else begin
          srv[L] = srv[L] | hs;
        end
        if (pushed) begin
          q.push_back(w);
          if (L == 0 && feed_a.size() != 0) void'(feed_a.pop_front());
          if (L == 1 && feed_d.size() != 0) void'(feed_d.pop_front());
        end
        if (L == 0) mqa = q; else mqd = q;
      end
    end
    if (!rst_n) begin
      model_reset();
    end
`ifdef IACT_ROUTER_SEL_LOCK_EN
    else if (!busy_m) begin
      m_in  = in_sel;
      m_out = out_sel;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic run_feed(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      drive_feed();
      step();
    end
  endtask

  initial begin
    in_sel = 2'd0;
    out_sel = 2'd0;
    src_av = 4'b0;
    src_dv = 4'b0;
    dst_ar = 4'b0;
    dst_dr = 4'b0;
    for (int i = 0; i < 4; i++) begin
      src_a[i] = '0;
      src_d[i] = '0;
    end
    model_reset();
    #12;
    check("reset_addr_valid", 32'(a_ov), 32'h0);
    check("reset_data_valid", 32'(d_ov), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_glb_ready", 32'(a_rdy), 32'h1);
    step();
    rst_n = 1'b1;

    // Unicast from GLB.
    dst_ar = 4'b0001; dst_dr = 4'b0001;
    feed_a.push_back(16'h15); feed_d.push_back(16'hABC);
    run_feed(4);

    // Staggered broadcast from north.
    in_sel = 2'd1; out_sel = 2'd3;
    dst_ar = 4'b0; dst_dr = 4'b0;
    run_feed(1);
    feed_a.push_back(16'h2A); feed_d.push_back(16'h5C3);
    run_feed(1);
    for (int c = 0; c < 6; c++) begin
      case (c)
        1: begin dst_ar = 4'b0001; dst_dr = 4'b0001; end
        2: begin dst_ar = 4'b1000; dst_dr = 4'b1000; end
        4: begin dst_ar = 4'b0110; dst_dr = 4'b0110; end
        default: begin dst_ar = 4'b0; dst_dr = 4'b0; end
      endcase
      run_feed(1);
    end

    // Full / backpressure: three words against a stalled PE.
    in_sel = 2'd0; out_sel = 2'd0;
    run_feed(1);
    for (int k = 0; k < 3; k++) begin
      feed_a.push_back(16'(k + 3));
      feed_d.push_back(16'(12'h100 + k));
    end
    run_feed(5);
    dst_ar = 4'b0001; dst_dr = 4'b0001;
    run_feed(6);

    // Streaming vertical multicast from south.
    in_sel = 2'd2; out_sel = 2'd2;
    run_feed(1);
    dst_ar = 4'hF; dst_dr = 4'hF;
    for (int k = 0; k < 16; k++) begin
      feed_a.push_back(16'(k));
      feed_d.push_back(16'(k));
    end
    run_feed(20);

    // Out-select change while two entries are queued.
    in_sel = 2'd0; out_sel = 2'd0;
    dst_ar = 4'b0; dst_dr = 4'b0;
    run_feed(1);
    feed_a.push_back(16'h11); feed_d.push_back(16'h211);
    feed_a.push_back(16'h22); feed_d.push_back(16'h322);
    run_feed(3);
    out_sel = 2'd3;
    dst_ar = 4'hF; dst_dr = 4'hF;
    run_feed(4);
    feed_a.push_back(16'h33); feed_d.push_back(16'h433);
    run_feed(4);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) in_sel = 2'($urandom);
      if ($urandom_range(0, 19) == 0) out_sel = 2'($urandom);
      src_av = 4'($urandom);
      src_dv = 4'($urandom);
      dst_ar = 4'($urandom) | 4'($urandom);
      dst_dr = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        src_a[i] = ADDR_W'($urandom);
        src_d[i] = DATA_W'($urandom);
      end
      step();
    end

    // Reset with a partially served broadcast head and a full FIFO.
    src_av = 4'b0; src_dv = 4'b0;
    dst_ar = 4'b0; dst_dr = 4'b0;
    in_sel = 2'd0; out_sel = 2'd3;
    run_feed(4);
    feed_a.push_back(16'h41); feed_d.push_back(16'h641);
    feed_a.push_back(16'h42); feed_d.push_back(16'h642);
    run_feed(1);
    dst_ar = 4'b0001; dst_dr = 4'b0001;
    run_feed(1);
    dst_ar = 4'b0; dst_dr = 4'b0;
    src_av = 4'b0; src_dv = 4'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_addr_valid", 32'(a_ov), 32'h0);
    check("midreset_data_valid", 32'(d_ov), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    feed_a.push_back(16'h5A); feed_d.push_back(16'h7A5);
    dst_ar = 4'hF; dst_dr = 4'hF;
    run_feed(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/iact_router_buffered.md
# iact_router_buffered

Parametrised, buffered successor to the iact circuit-switching router. It selects one of four sources (GLB, north, south, horiz) with `data_in_sel`, buffers the address and data lanes in independent FIFOs, and forks each head entry to PE plus the north, south and horiz destinations that `data_out_sel` enables. Destination acceptance is tracked per destination, so a multicast completes even when the destinations accept in different cycles. One instance sits between each iact SRAM and its PE in the PE cluster.

## Interface
- `ADDR_W`, 7: address lane width.
- `DATA_W`, 12: data lane width.
- `FIFO_DEPTH`, 2: entries per lane FIFO; must be a power of two and ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `{GLB,north,south,horiz}_address_in_valid`  in  1  source address valid.
- `{GLB,north,south,horiz}_address_in`  in  ADDR_W  source address.
- `{GLB,north,south,horiz}_address_in_ready`  out  1  source address ready.
- `{GLB,north,south,horiz}_data_in_valid`  in  1  source data valid.
- `{GLB,north,south,horiz}_data_in`  in  DATA_W  source data.
- `{GLB,north,south,horiz}_data_in_ready`  out  1  source data ready.
- `{PE,north,south,horiz}_address_out_valid`  out  1  destination address valid.
- `{PE,north,south,horiz}_address_out`  out  ADDR_W  address FIFO head.
- `{PE,north,south,horiz}_address_out_ready`  in  1  destination address ready.
- `{PE,north,south,horiz}_data_out_valid` / `_data_out` / `_data_out_ready`: the same three signals for the data lane, `_data_out` DATA_W wide.
- `data_in_sel`  in  2  source select: 0 GLB, 1 north, 2 south, 3 horiz.
- `data_out_sel`  in  2  destination select: 0 UNICAST (PE), 1 HOR_CAST (PE+horiz), 2 VER_CAST (PE+north+south), 3 BROADCAST (all four).
- `busy`  out  1  high when either lane holds an entry or has a served bit set.

## Operation
- The address lane and data lane are identical and independent. Each lane has:
  - a FIFO with write pointer, read pointer, and count of width $clog2(FIFO_DEPTH+1);
  - a 4-bit `served` vector covering PE, north, south and horiz.
- Input side:
  - `S_*_in_ready` = (effective in_sel == S) & (count < FIFO_DEPTH).
  - Unselected sources always see ready = 0.
  - A push occurs when the selected valid and ready are both high.
- Enabled set E: derived from the effective out_sel. PE is always in E.
- Output side:
  - `d_*_out_valid` = (count ≠ 0) & (d ∈ E) & ~served[d].
  - Out data for every destination is the FIFO head.
- Destination handshake: a cycle with valid & ready on destination d sets served[d].
- Pop: occurs when every d ∈ E is either already served or handshakes this cycle. On pop, the read pointer advances and `served` clears to 0.
- Served bits for destinations outside E are ignored in the pop test.
- Push and pop in the same cycle leave count unchanged. This is legal when full, but ready is computed from the current count only; there is no full-bypass.
- Pointers wrap from FIFO_DEPTH-1 to 0.
- VER_CAST waits on both north and south.

## Timing
- Reset (rst_n low, asynchronous):
  - counts, pointers and served vectors clear to 0;
  - every `*_out_valid` = 0 and `busy` = 0;
  - with the macro defined, the select registers clear to GLB / UNICAST;
  - `*_in_ready` follows the combinational rule (selected source sees 1).
- Latency: 1 cycle. A push at edge N gives out_valid high after edge N.
- Throughput:
  - 1 entry per cycle per lane when all destinations in E are ready and FIFO_DEPTH ≥ 2;
  - with FIFO_DEPTH = 1, at most 1 entry every 2 cycles.
- Out payload and valid stay stable until the per-destination handshake; valid never deasserts before served.
- If rst_n is asserted mid-transfer, buffered entries are dropped; no partial-multicast state survives.

## Configuration
- `IACT_ROUTER_SEL_LOCK_EN` defined:
  - `data_in_sel` and `data_out_sel` are registered into the effective selects;
  - the registers load only on a cycle where `busy` = 0;
  - while busy, select changes are ignored until the router drains.
- Undefined:
  - the effective selects are the raw inputs;
  - the caller must hold them stable while `busy` = 1;
  - a mid-transfer out_sel change alters E immediately, including for a partially served head.

## Test plan
- **Unicast:** GLB sel, UNICAST, PE ready = 1; push address 0x15 and data 0xABC. Expect PE valid the next cycle, 0x15 and 0xABC delivered, north/south/horiz valid = 0.
- **Staggered broadcast:** north sel, BROADCAST; PE ready at cycle 1, horiz at cycle 2, north+south at cycle 4. Expect each destination to see exactly one handshake; pop at cycle 4; busy = 0 after.
- **Full / backpressure:** FIFO_DEPTH = 2, PE ready = 0, push 3 words. Expect in_ready = 0 after 2 words. Releasing PE ready gives 3 words in order with no loss.
- **Streaming:** VER_CAST, all destinations always ready, 16 back-to-back data words 0..15 from south. Expect 1 word per cycle on PE, north and south, in order.
- **Select lock:** with the macro defined, change out_sel from UNICAST to BROADCAST while 2 entries are queued. Expect both entries to go to PE only, then broadcast applies once `busy` = 0.
- **Reset mid-operation:** assert rst_n low with served = {PE} and count = 2. Expect all valids = 0 immediately and count = 0; after release, the next push behaves as fresh.
